fetch_vec_irq: RTL and testbench
================================

# fetch_vec_irq

Parametrised program-counter and vectored-interrupt front end for the pipelined MIPS core. It holds the PC and selects the next fetch address from reset, sequential, branch or trap sources. It latches NUM_IRQ interrupt lines into pending bits and redirects fetch to a per-line vector. Return addresses go on an EPC stack, so a higher-priority interrupt may preempt a lower-priority handler up to NEST_DEPTH levels, and `rti` unwinds the stack.

## Interface
Parameters:
- AW, 32: PC/address width.
- NUM_IRQ, 4: interrupt lines, 1..16. Index 0 has the highest priority.
- NEST_DEPTH, 4: EPC stack entries, 1..8.
- RESET_ADDRESS, 0: PC after reset; also the target for pc_sel=00.
- TRAP_ADDRESS, 'h80: target for pc_sel=01.
- VECTOR_BASE, 'h100: vector of line 0.
- VECTOR_STRIDE, 'h10: vector spacing. Vector of line i = VECTOR_BASE + i*VECTOR_STRIDE, truncated to AW.
- PC_INC, 1: sequential increment (word addressing).

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- stall, in, 1: freezes PC and blocks interrupt entry/exit.
- pc_sel, in, 2: next-PC source. 00 = reset address, 01 = trap, 10 = sequential, 11 = branch.
- pc_branch, in, AW: branch/jump target.
- irq, in, NUM_IRQ: interrupt request lines.
- irq_mask, in, NUM_IRQ: 1 = line enabled.
- rti, in, 1: return from interrupt; valid for one cycle.
- pc, out, AW: current fetch address.
- pc_inc, out, AW: pc + PC_INC, modulo 2^AW.
- irq_ack, out, 1: one-cycle pulse on the cycle an interrupt is taken.
- irq_id, out, clog2(NUM_IRQ): line taken. Valid with irq_ack; otherwise holds the last value.
- depth, out, clog2(NEST_DEPTH+1): current nesting level.
- rti_err, out, 1: one-cycle pulse when rti arrives with an empty stack.

## Operation
Next-PC selection:
- Normal next PC `npc`: pc_sel selects RESET_ADDRESS, TRAP_ADDRESS, pc_inc or pc_branch.
- A trap does not push the stack.

Pending bits:
- pending[i] is set when irq[i] is seen at 1 after being 0 in the previous cycle.
- pending[i] is cleared only when line i is taken. Set has priority over clear only for a new edge.
- Masked lines still latch pending but are not eligible.

Eligibility and priority:
- Eligible = pending & irq_mask.
- The winner is the lowest eligible index w.
- Preemption limit: w must be strictly lower than the line on top of the stack. With an empty stack any w qualifies.

Take condition (all must hold): !stall, !rti, winner exists and qualifies, depth < NEST_DEPTH. When taken:
- PC ← vector(w).
- Push {npc, w}; depth increments.
- pending[w] clears; irq_ack=1; irq_id=w.

rti with !stall and depth>0:
- PC ← top.return_addr; pop; depth decrements.
- No interrupt is taken that cycle. Pending interrupts are evaluated on the next cycle against the new top.

rti with depth=0: rti_err pulses and PC follows npc.

Stall:
- PC, stack and depth hold.
- Pending still captures edges.
- rti, pc_sel and interrupt take are ignored.

Reset: pc=RESET_ADDRESS, pending=0, stack empty, depth=0, irq_ack=0, irq_id=0, rti_err=0. Reset mid-handler discards all nesting.

## Timing
- irq rising edge sampled at clock edge n sets pending; the interrupt is taken at edge n+1, so pc=vector appears after n+1. Latency is 2 edges from assertion.
- irq_ack and rti_err are registered pulses, coincident with the PC update.
- pc_inc is combinational from pc. All other outputs are registered.
- If an irq edge arrives on the same cycle its line is taken, pending stays set (new edge wins) and the line re-fires later.
- Stack full: eligible interrupts wait in pending with no loss.

## Structure
- Shared package `fetch_pkg`: pc_sel encodings PCSEL_RESET/TRAP/SEQ/BRANCH, and a stack entry struct {addr, id}.
- Sub-module `epc_stack`: parametrised LIFO of depth NEST_DEPTH with push/pop, top, depth, full and empty outputs.
- The priority encoder and vector arithmetic live in the top module.

## Test plan
- Reset, then pc_sel=10 for 3 cycles: pc = 0,1,2,3; depth=0; no ack.
- irq[2] rises with mask=4'hF at pc=5: two edges later pc='h120, irq_ack=1, irq_id=2, depth=1. rti then gives pc=6 (the saved npc) and depth=0.
- In handler 2, irq[0] rises: preempt to 'h100, depth=2. irq[3] rises: no take until both rti's complete, then take 3 → 'h130.
- irq[1] and irq[3] rise together with mask=4'b1000: line 3 is taken. Line 1 stays pending and is taken when the mask is set, provided the stack top is >1 or the stack is empty.
- NEST_DEPTH=2: nest two levels, raise a higher-priority line: no take while full. After rti it is taken. rti at depth 0 → rti_err=1 and pc=npc.
- stall held 3 cycles during an irq edge and a coincident rti: pc, depth and stack unchanged. The take occurs on the first unstalled cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch/vectored-interrupt front end.
// Stack entries use fixed maximum widths; users truncate to their own AW/id width.
package fetch_pkg;
    localparam int ADDR_MAX = 64;
    localparam int ID_MAX   = 4;

    typedef enum logic [1:0] {
        PCSEL_RESET  = 2'b00,
        PCSEL_TRAP   = 2'b01,
        PCSEL_SEQ    = 2'b10,
        PCSEL_BRANCH = 2'b11
    } pc_sel_e;

    typedef struct packed {
        logic [ADDR_MAX-1:0] addr;
        logic [ID_MAX-1:0]   id;
    } epc_entry_t;
endpackage

// File: rtl/epc_stack.sv
// LIFO of interrupt return entries; push/pop take effect on the next clock edge.
// Push while full and pop while empty are ignored.
module epc_stack
    import fetch_pkg::*;
#(
    parameter int NEST_DEPTH = 4,
    localparam int DW = $clog2(NEST_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  epc_entry_t    push_dat,
    output epc_entry_t    top_dat,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    // Sized to the full index range of depth_q so any index stays in bounds.
    epc_entry_t    entries_q [2**DW];
    epc_entry_t    entries_d [2**DW];
    logic [DW-1:0] depth_q, depth_d;

    assign full    = (depth_q == DW'(NEST_DEPTH));
    assign empty   = (depth_q == '0);
    assign depth   = depth_q;
    assign top_dat = entries_q[depth_q - DW'(1)];

    always_comb begin
        entries_d = entries_q;
        depth_d   = depth_q;
        if (push && !full) begin
            entries_d[depth_q] = push_dat;
            depth_d            = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) depth_q <= '0;
        else       depth_q <= depth_d;
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end
endmodule

// File: rtl/fetch_vec_irq.sv
// PC register with next-PC select, edge-latched vectored interrupts and nested EPC stack.
// Interrupt taken one edge after the pending bit sets; stall freezes PC/stack but not edge capture.
module fetch_vec_irq
    import fetch_pkg::*;
#(
    parameter int           AW            = 32,
    parameter int           NUM_IRQ       = 4,
    parameter int           NEST_DEPTH    = 4,
    parameter logic [AW-1:0] RESET_ADDRESS = '0,
    parameter logic [AW-1:0] TRAP_ADDRESS  = AW'('h80),
    parameter logic [AW-1:0] VECTOR_BASE   = AW'('h100),
    parameter logic [AW-1:0] VECTOR_STRIDE = AW'('h10),
    parameter logic [AW-1:0] PC_INC        = AW'(1),
    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int DW  = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [1:0]         pc_sel,
    input  logic [AW-1:0]      pc_branch,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               rti,
    output logic [AW-1:0]      pc,
    output logic [AW-1:0]      pc_inc,
    output logic               irq_ack,
    output logic [IDW-1:0]     irq_id,
    output logic [DW-1:0]      depth,
    output logic               rti_err
);
    logic [AW-1:0]      pc_q, pc_d, npc, vec;
    logic [NUM_IRQ-1:0] pending_q, pending_d, irq_prev_q, irq_prev_d, elig, clr;
    logic               irq_ack_q, irq_ack_d, rti_err_q, rti_err_d;
    logic [IDW-1:0]     irq_id_q, irq_id_d, win_idx;
    logic               win_vld, qualifies, take, pop;
    logic               stk_full, stk_empty;
    epc_entry_t         push_dat, top_dat;

    assign pc_inc = pc_q + PC_INC;

    always_comb begin
        case (pc_sel_e'(pc_sel))
            PCSEL_RESET:  npc = RESET_ADDRESS;
            PCSEL_TRAP:   npc = TRAP_ADDRESS;
            PCSEL_SEQ:    npc = pc_inc;
            default:      npc = pc_branch;
        endcase
    end

    // Lowest eligible index wins.
    assign elig = pending_q & irq_mask;
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_vld = 1'b1;
                win_idx = IDW'(i);
            end
        end
    end

    assign vec       = VECTOR_BASE + AW'(win_idx) * VECTOR_STRIDE;
    assign qualifies = stk_empty || (win_idx < top_dat.id[IDW-1:0]);
    assign take      = !stall && !rti && win_vld && qualifies && !stk_full;
    assign pop       = !stall && rti && !stk_empty;
    assign push_dat  = '{addr: ADDR_MAX'(npc), id: ID_MAX'(win_idx)};

    always_comb begin
        pc_d      = pc_q;
        irq_ack_d = 1'b0;
        irq_id_d  = irq_id_q;
        rti_err_d = 1'b0;
        clr       = '0;
        if (!stall) begin
            if (rti) begin
                if (!stk_empty) begin
                    pc_d = top_dat.addr[AW-1:0];
                end else begin
                    rti_err_d = 1'b1;
                    pc_d      = npc;
                end
            end else if (take) begin
                pc_d      = vec;
                irq_ack_d = 1'b1;
                irq_id_d  = win_idx;
                clr       = NUM_IRQ'(1) << win_idx;
            end else begin
                pc_d = npc;
            end
        end
        // A fresh edge on the line being taken keeps it pending.
        irq_prev_d = irq;
        pending_d  = (pending_q & ~clr) | (irq & ~irq_prev_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_ADDRESS;
            pending_q  <= '0;
            irq_prev_q <= '0;
            irq_ack_q  <= 1'b0;
            irq_id_q   <= '0;
            rti_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_prev_d;
            irq_ack_q  <= irq_ack_d;
            irq_id_q   <= irq_id_d;
            rti_err_q  <= rti_err_d;
        end
    end

    epc_stack #(.NEST_DEPTH(NEST_DEPTH)) u_epc_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (take),
        .pop      (pop),
        .push_dat (push_dat),
        .top_dat  (top_dat),
        .depth    (depth),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    assign pc      = pc_q;
    assign irq_ack = irq_ack_q;
    assign irq_id  = irq_id_q;
    assign rti_err = rti_err_q;
endmodule

// File: tb/tb_fetch_vec_irq.sv
// Directed bench for fetch_vec_irq with a two-deep EPC stack so the full case is reachable.
module tb_fetch_vec_irq;
    localparam logic [1:0] SEL_RST = 2'b00, SEL_TRAP = 2'b01, SEL_SEQ = 2'b10, SEL_BR = 2'b11;

    logic        clk, reset, stall, rti;
    logic [1:0]  pc_sel;
    logic [31:0] pc_branch, pc, pc_inc;
    logic [3:0]  irq, irq_mask;
    logic        irq_ack, rti_err;
    logic [1:0]  irq_id, depth;

    int n_cmp = 0;
    int n_err = 0;

    fetch_vec_irq #(.NEST_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .pc_sel    (pc_sel),
        .pc_branch (pc_branch),
        .irq       (irq),
        .irq_mask  (irq_mask),
        .rti       (rti),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .irq_ack   (irq_ack),
        .irq_id    (irq_id),
        .depth     (depth),
        .rti_err   (rti_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [31:0] e_pc, input logic e_ack, input logic [1:0] e_dep);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".ack"}, 32'(irq_ack), 32'(e_ack));
        chk({tag, ".depth"}, 32'(depth), 32'(e_dep));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; rti = 1'b0; pc_sel = SEL_SEQ;
        pc_branch = '0; irq = '0; irq_mask = 4'hF;
        step(); step();
        reset = 1'b0;
        st("reset", 32'h0, 1'b0, 2'd0);
        chk("reset.id", 32'(irq_id), 32'd0);
        chk("reset.rti_err", 32'(rti_err), 32'd0);
        chk("reset.pc_inc", pc_inc, 32'h1);

        // Sequential fetch
        step(); st("seq1", 32'h1, 1'b0, 2'd0);
        step(); st("seq2", 32'h2, 1'b0, 2'd0);
        step(); st("seq3", 32'h3, 1'b0, 2'd0);
        step();
        irq = 4'b0100;
        step(); st("irq2_pend", 32'h5, 1'b0, 2'd0);
        step(); st("irq2_take", 32'h120, 1'b1, 2'd1);
        chk("irq2_take.id", 32'(irq_id), 32'd2);
        step(); st("h2_run", 32'h121, 1'b0, 2'd1);
        chk("h2_run.id_hold", 32'(irq_id), 32'd2);

        // Preempt by line 0, then line 3 waits until both handlers return
        irq = 4'b0101;
        step(); st("irq0_pend", 32'h122, 1'b0, 2'd1);
        step(); st("irq0_take", 32'h100, 1'b1, 2'd2);
        chk("irq0_take.id", 32'(irq_id), 32'd0);
        irq = 4'b1101;
        step(); st("irq3_wait1", 32'h101, 1'b0, 2'd2);
        step(); st("irq3_wait2", 32'h102, 1'b0, 2'd2);
        rti = 1'b1;
        step(); st("rti_h0", 32'h123, 1'b0, 2'd1);
        rti = 1'b0;
        step(); st("irq3_blocked", 32'h124, 1'b0, 2'd1);
        rti = 1'b1;
        step(); st("rti_h2", 32'h6, 1'b0, 2'd0);
        rti = 1'b0;
        step(); st("irq3_take", 32'h130, 1'b1, 2'd1);
        chk("irq3_take.id", 32'(irq_id), 32'd3);
        rti = 1'b1;
        step(); st("rti_h3", 32'h7, 1'b0, 2'd0);
        rti = 1'b0;
        irq = 4'b0000;
        step(); st("idle", 32'h8, 1'b0, 2'd0);

        // Masked line 1 stays pending while 3 runs
        irq_mask = 4'b1000;
        irq = 4'b1010;
        step(); st("mask_pend", 32'h9, 1'b0, 2'd0);
        step(); st("mask_take3", 32'h130, 1'b1, 2'd1);
        chk("mask_take3.id", 32'(irq_id), 32'd3);
        step(); st("mask_hold1", 32'h131, 1'b0, 2'd1);
        irq_mask = 4'hF;
        step(); st("unmask_take1", 32'h110, 1'b1, 2'd2);
        chk("unmask_take1.id", 32'(irq_id), 32'd1);

        // Stack full: line 0 waits in pending
        irq = 4'b1011;
        step(); st("full_pend", 32'h111, 1'b0, 2'd2);
        step(); st("full_block", 32'h112, 1'b0, 2'd2);
        rti = 1'b1;
        step(); st("full_rti", 32'h132, 1'b0, 2'd1);
        rti = 1'b0;
        step(); st("full_take0", 32'h100, 1'b1, 2'd2);
        chk("full_take0.id", 32'(irq_id), 32'd0);
        rti = 1'b1;
        step(); st("unwind1", 32'h133, 1'b0, 2'd1);
        step(); st("unwind2", 32'hA, 1'b0, 2'd0);
        chk("unwind2.rti_err", 32'(rti_err), 32'd0);
        step(); st("rti_empty", 32'hB, 1'b0, 2'd0);
        chk("rti_empty.rti_err", 32'(rti_err), 32'd1);
        rti = 1'b0;
        step(); st("after_err", 32'hC, 1'b0, 2'd0);
        chk("after_err.rti_err", 32'(rti_err), 32'd0);
        chk("after_err.id_hold", 32'(irq_id), 32'd0);

        // Stall with irq edge, rti and branch all ignored until released
        irq = 4'b0000;
        step(); st("pre_stall", 32'hD, 1'b0, 2'd0);
        irq = 4'b0100;
        step(); st("s_pend", 32'hE, 1'b0, 2'd0);
        step(); st("s_take2", 32'h120, 1'b1, 2'd1);
        stall = 1'b1; rti = 1'b1; irq = 4'b0101;
        pc_sel = SEL_BR; pc_branch = 32'h55;
        for (int k = 0; k < 3; k++) begin
            step(); st("stall", 32'h120, 1'b0, 2'd1);
            chk("stall.rti_err", 32'(rti_err), 32'd0);
        end
        stall = 1'b0; rti = 1'b0; pc_sel = SEL_SEQ;
        step(); st("unstall_take0", 32'h100, 1'b1, 2'd2);
        chk("unstall_take0.id", 32'(irq_id), 32'd0);
        rti = 1'b1;
        step(); st("s_rti1", 32'h121, 1'b0, 2'd1);
        step(); st("s_rti2", 32'hF, 1'b0, 2'd0);
        rti = 1'b0;

        // Branch, trap, reset selects
        pc_sel = SEL_BR; pc_branch = 32'h55;
        step(); st("branch", 32'h55, 1'b0, 2'd0);
        chk("branch.pc_inc", pc_inc, 32'h56);
        pc_sel = SEL_TRAP;
        step(); st("trap", 32'h80, 1'b0, 2'd0);
        pc_sel = SEL_RST;
        step(); st("sel_reset", 32'h0, 1'b0, 2'd0);
        pc_sel = SEL_SEQ;
        irq = 4'b0000;
        step(); st("seq_again", 32'h1, 1'b0, 2'd0);

        // Reset in the middle of a handler
        irq = 4'b0001;
        step(); st("r_pend", 32'h2, 1'b0, 2'd0);
        step(); st("r_take0", 32'h100, 1'b1, 2'd1);
        reset = 1'b1;
        step(); st("mid_reset", 32'h0, 1'b0, 2'd0);
        chk("mid_reset.id", 32'(irq_id), 32'd0);
        reset = 1'b0;
        step(); st("post_reset", 32'h1, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
